mux_n_rr: RTL
=============

Name: mux_n_rr

Overview:
- Parametrised successor to the 2:1 word mux: N-channel, WIDTH-bit selector with a registered output stage and valid/ready handshakes.
- Two selection modes: explicit channel select (`controle`) or round-robin arbitration among valid channels.
- Sits between multiple producers (datapath units, register ports) and a single consumer that may stall.

Parameters:
- WIDTH, 32, data width of each channel and of `saida`
- N, 4, number of input channels (2..16)
- SELW, $clog2(N), width of `controle` and `canal`

Ports:
- Clock  input  1  system clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- entrada  input  N*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH]
- entrada_valida  input  N  per-channel valid
- entrada_pronta  output  N  per-channel ready, one-hot or zero
- modo  input  1  0 = fixed select via `controle`; 1 = round-robin
- controle  input  SELW  channel index used when modo=0
- saida  output  WIDTH  registered selected data
- saida_valida  output  1  `saida` holds an unconsumed word
- saida_pronta  input  1  consumer ready
- canal  output  SELW  index of the channel that supplied `saida`

Behaviour:
- Reset (Reset_n=0, asynchronous, any time):
  - Applies immediately: saida=0, saida_valida=0, canal=0, rr_ptr=0.
  - Any word in flight is discarded.
  - entrada_pronta=0 while reset is asserted.
- Slot free: `livre = !saida_valida || saida_pronta` (combinational).
- Grant is combinational:
  - modo=0: grant channel `controle` iff livre and entrada_valida[controle]. If controle >= N, no grant.
  - modo=1: grant the first k with entrada_valida[k]=1, searching rr_ptr, rr_ptr+1, … N-1, 0, … rr_ptr-1 (wrap-around), iff livre.
- entrada_pronta[k] = 1 only for the granted channel. A transfer on channel k occurs when entrada_valida[k] and entrada_pronta[k] are both 1.
- On a transfer (rising edge):
  - saida <= granted data; canal <= k; saida_valida <= 1.
  - In modo=1 only: rr_ptr <= (k == N-1) ? 0 : k+1.
  - rr_ptr is not updated in modo=0.
- Latency: one cycle from the accepting edge to the word appearing on `saida`.
- Throughput: one word per cycle when the consumer is always ready.
- Consumer handshake:
  - If saida_valida=1 and saida_pronta=1 and there is no new grant: saida_valida <= 0. `saida` keeps its value.
  - Simultaneous consume and new grant: saida_valida stays 1 and the new word loads. No bubble.
- Stall: while saida_valida=1 and saida_pronta=0:
  - saida and canal hold.
  - entrada_pronta = 0.
  - Producers must hold their data.
- Mode switching: `modo` may change on any cycle. It takes effect for the grant in the same cycle. rr_ptr is retained across mode changes.
- No valid inputs: no grant, no state change except consumption.

Optional Feature:
- Macro: `MUX_N_RR_PARIDADE_EN`.
- Defined:
  - Extra output `saida_paridade` (1 bit) = even parity (XOR reduction) of the `saida` word, registered alongside `saida`.
  - Reset value 0.
  - Holds with `saida` during a stall.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Decomposition:
- Package `mux_n_pkg` holds:
  - localparam MODO_FIXO=1'b0, MODO_RR=1'b1
  - function `next_ptr(k, N)` for wrap-around
  - function `paridade(word)`
- Sub-module `rr_arbiter` (N-bit request in, rr_ptr in, one-hot grant plus index out, purely combinational). It is the natural split and is reusable by future multi-port blocks.

Test Plan:
1. Reset with Reset_n=0 mid-stream (saida_valida=1, saida=0x8000_1234) -> saida=0, saida_valida=0, entrada_pronta=0 immediately, without waiting for a clock edge.
2. Fixed select, N=4, modo=0, controle=2, all valid, entrada ch2=0xDEAD_BEEF, saida_pronta=1 -> entrada_pronta=4'b0100; next edge saida=0xDEAD_BEEF, canal=2. With controle=2 and entrada_valida=4'b1011 -> no grant, saida_valida drops after consume.
3. Round-robin fairness: modo=1, all 4 valid, saida_pronta=1 for 8 cycles -> canal sequence 0,1,2,3,0,1,2,3 on consecutive cycles. With entrada_valida=4'b1001 starting at rr_ptr=1 -> grants 3,0,3,0.
4. Backpressure: saida_valida=1, saida_pronta=0 for 3 cycles -> saida and canal stable, entrada_pronta=0. Raising saida_pronta with a valid input -> back-to-back transfer, no bubble cycle.
5. Random sweep: 200 cycles of random data with MSB=1 (negative values), random modo/controle/valid/pronta. A scoreboard checks every transfer's data/canal against a reference queue, and checks that entrada_pronta is never set when controle >= N.
6. Parity (with `MUX_N_RR_PARIDADE_EN` defined): saida=0x0000_0007 -> saida_paridade=1; saida=0xFFFF_FFFF -> saida_paridade=0. Build without the macro compiles and passes tests 1-5.

Source files
------------

// File: rtl/mux_n_pkg.sv
// Purpose : shared constants and helpers for the N-channel registered selector.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package mux_n_pkg;

    localparam logic MODO_FIXO = 1'b0;   // explicit channel select via controle
    localparam logic MODO_RR   = 1'b1;   // round-robin among valid channels

    // Widest word the parity helper accepts; callers zero-extend to this width.
    localparam int MAX_WIDTH = 256;

    // Round-robin pointer advance with wrap-around at the last channel.
    function automatic int next_ptr(input int k, input int n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction

    // XOR reduction of a word; zero-extension does not change the result.
    function automatic logic paridade(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin arbiter, search starts at ptr and wraps.
// Latency : 0 cycles (purely combinational).
// Backpressure: none; the caller gates the grant with its own slot-free condition.
// Ports: req[N] requests in, ptr[SELW] starting channel in,
//        grant[N] one-hot out, grantIdx[SELW] granted index out, anyGrant out.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grantIdx,
    output logic            anyGrant
);

    // One extra bit so ptr + i never overflows before the wrap subtraction.
    logic [SELW:0] idx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (SELW+1)'(i);
            if (idx >= (SELW+1)'(N)) begin
                idx = idx - (SELW+1)'(N);
            end
            if (!anyGrant && req[idx[SELW-1:0]]) begin
                anyGrant                = 1'b1;
                grantIdx                = idx[SELW-1:0];
                grant[idx[SELW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_rr.sv
// Purpose : N-channel WIDTH-bit selector, fixed or round-robin, registered output.
// Latency : 1 cycle from accepting edge to word on saida; one word per cycle sustained.
// Backpressure: while saida is held unconsumed, all entrada_pronta drop and saida/canal hold.
// Ports: Clock, Reset_n (async active-low); entrada[N*WIDTH] / entrada_valida[N] /
//        entrada_pronta[N] producer side; modo, controle select; saida / saida_valida /
//        saida_pronta / canal consumer side. With MUX_N_RR_PARIDADE_EN defined an extra
//        registered output saida_paridade carries the XOR reduction of saida.
module mux_n_rr
    import mux_n_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [N*WIDTH-1:0] entrada,
    input  logic [N-1:0]       entrada_valida,
    output logic [N-1:0]       entrada_pronta,
    input  logic               modo,
    input  logic [SELW-1:0]    controle,
    output logic [WIDTH-1:0]   saida,
    output logic               saida_valida,
    input  logic               saida_pronta,
    output logic [SELW-1:0]    canal
`ifdef MUX_N_RR_PARIDADE_EN
    ,
    output logic               saida_paridade
`endif
);

    logic [SELW-1:0]  rrPtr;
    logic             livre;
    logic             ctrlInRange;
    logic [N-1:0]     rrGrant;
    logic [SELW-1:0]  rrIdx;
    logic             rrAny;
    logic [N-1:0]     grantVec;
    logic [SELW-1:0]  grantIdx;
    logic             doXfer;
    logic [WIDTH-1:0] selData;

    // The output register can take a word if empty or being drained this cycle.
    assign livre       = !saida_valida || saida_pronta;
    // controle is wider than needed for non-power-of-two N; out-of-range means no grant.
    assign ctrlInRange = ({1'b0, controle} < (SELW+1)'(N));

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) uArb (
        .req      (entrada_valida),
        .ptr      (rrPtr),
        .grant    (rrGrant),
        .grantIdx (rrIdx),
        .anyGrant (rrAny)
    );

    always_comb begin
        grantVec = '0;
        grantIdx = '0;
        doXfer   = 1'b0;
        // Gating with Reset_n keeps every ready low for the whole reset assertion.
        if (Reset_n && livre) begin
            if (modo == MODO_FIXO) begin
                if (ctrlInRange && entrada_valida[controle]) begin
                    grantVec[controle] = 1'b1;
                    grantIdx           = controle;
                    doXfer             = 1'b1;
                end
            end else if (rrAny) begin
                grantVec = rrGrant;
                grantIdx = rrIdx;
                doXfer   = 1'b1;
            end
        end
    end

    assign entrada_pronta = grantVec;
    assign selData        = entrada[grantIdx*WIDTH +: WIDTH];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            saida          <= '0;
            saida_valida   <= 1'b0;
            canal          <= '0;
            rrPtr          <= '0;
`ifdef MUX_N_RR_PARIDADE_EN
            saida_paridade <= 1'b0;
`endif
        end else if (doXfer) begin
            // A new word replaces any word consumed this same cycle: no bubble.
            saida        <= selData;
            canal        <= grantIdx;
            saida_valida <= 1'b1;
`ifdef MUX_N_RR_PARIDADE_EN
            saida_paridade <= paridade(MAX_WIDTH'(selData));
`endif
            // Fixed-select traffic leaves the round-robin position untouched.
            if (modo == MODO_RR) begin
                rrPtr <= SELW'(next_ptr(int'(grantIdx), N));
            end
        end else if (saida_pronta) begin
            // Consumed with nothing to replace it; saida keeps its last value.
            saida_valida <= 1'b0;
        end
    end

endmodule
